// File: rtl/rev_step_driver_pkg.sv
// Shared types and constants for the reversible-counter step driver.
package rev_step_driver_pkg;

  localparam int unsigned DEF_WIDTH = 16;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StStep,
    StGap,
    StFin
  } state_e;

endpackage

// File: rtl/rev_step_pacer.sv
// Step-rate divider: tick marks the last cycle of each STEP_DIV-cycle period while enabled.
module rev_step_pacer #(
  parameter int unsigned STEP_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d, phase;
  logic          en_q;

  // A rising enable restarts the period at phase 0.
  always_comb begin
    phase = (en && !en_q) ? '0 : cnt_q;
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = (phase == LAST) ? '0 : phase + 1'b1;
    end
    tick = en && (phase == LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      en_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      en_q  <= en;
    end
  end

endmodule

// File: rtl/rev_step_driver.sv
// Drives a reversible up/down counter to a target position, mirroring its value and checking Rc.
module rev_step_driver
  import rev_step_driver_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned STEP_DIV = 4,
  parameter bit          SHORTEST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] tgt,
  input  logic             abort,
  output logic             s,
  output logic             step,
  output logic [WIDTH-1:0] pos,
  input  logic             rc_in,
  output logic             busy,
  output logic             done,
  output logic             rc_err
);

  localparam logic [WIDTH-1:0] HALF = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pos_q, pos_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] diff;
  logic             s_q, s_d;
  logic             rc_err_q, rc_err_d;
  logic             rc_exp;
  logic             accept;
  logic             pace_en;
  logic             tick;

  assign diff    = tgt - pos_q;
  assign accept  = tgt_valid && tgt_ready;
  assign pace_en = (state_q == StStep) || (state_q == StGap);
  assign rc_exp  = s_q ? (&pos_q) : ~(|pos_q);

  rev_step_pacer #(
    .STEP_DIV(STEP_DIV)
  ) u_pacer (
    .clk  (clk),
    .rst  (rst),
    .en   (pace_en),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = (diff == '0) ? StFin : StSetup;
      end
      StSetup: state_d = abort ? StIdle : StStep;
      StStep: begin
        if (abort)                        state_d = StIdle;
        else if (rem_q == WIDTH'(1))      state_d = StFin;
        else if (STEP_DIV > 1)            state_d = StGap;
        else                              state_d = StStep;
      end
      StGap: begin
        if (abort)     state_d = StIdle;
        else if (tick) state_d = StStep;
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Direction is latched on acceptance so s has settled during SETUP, ahead of the first step.
  always_comb begin
    s_d      = s_q;
    rem_d    = rem_q;
    pos_d    = pos_q;
    rc_err_d = rc_err_q;
    if (accept && (diff != '0)) begin
      if (SHORTEST && (diff > HALF)) begin
        s_d   = DIR_DOWN;
        rem_d = -diff;
      end else begin
        s_d   = DIR_UP;
        rem_d = diff;
      end
    end
    if (state_q == StStep) begin
      pos_d = (s_q == DIR_UP) ? pos_q + 1'b1 : pos_q - 1'b1;
      rem_d = rem_q - 1'b1;
    end
    if (busy && (rc_in != rc_exp)) begin
      rc_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q    <= '0;
      rem_q    <= '0;
      s_q      <= DIR_DOWN;
      rc_err_q <= 1'b0;
    end else begin
      pos_q    <= pos_d;
      rem_q    <= rem_d;
      s_q      <= s_d;
      rc_err_q <= rc_err_d;
    end
  end

  always_comb begin
    tgt_ready = (state_q == StIdle) && !rst;
    busy      = (state_q == StSetup) || (state_q == StStep) || (state_q == StGap);
    step      = (state_q == StStep);
    done      = (state_q == StFin);
  end

  assign s      = s_q;
  assign pos    = pos_q;
  assign rc_err = rc_err_q;

endmodule

// File: tb/tb_rev_step_driver.sv
// Bench for rev_step_driver: three instances (STEP_DIV/SHORTEST variants) each with a model counter.
module tb_rev_step_driver;

  localparam int NI = 3;

  typedef struct {
    int          inst;
    logic [15:0] tgt;
    logic        exp_s;
    int          n;
    logic [15:0] exp_pos;
    int          lat;
  } vec_t;

  logic                clk = 1'b0;
  logic                rst;
  logic [15:0]         tgt;
  logic                abort;
  logic [NI-1:0]       valid, ready, s, step, busy, done, rc_err, rc_in, rc_force;
  logic [NI-1:0][15:0] pos;

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] model_pos [NI];
  vec_t        vecs [10];

  always #5 clk = ~clk;

  for (genvar i = 0; i < NI; i++) begin : g_dut
    logic [15:0] cnt;

    rev_step_driver #(
      .WIDTH    (16),
      .STEP_DIV ((i == 1) ? 4 : 1),
      .SHORTEST ((i == 2) ? 1'b0 : 1'b1)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .tgt_valid (valid[i]),
      .tgt_ready (ready[i]),
      .tgt       (tgt),
      .abort     (abort),
      .s         (s[i]),
      .step      (step[i]),
      .pos       (pos[i]),
      .rc_in     (rc_in[i]),
      .busy      (busy[i]),
      .done      (done[i]),
      .rc_err    (rc_err[i])
    );

    // External counter model; Rc is combinational from its value and s.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt <= '0;
      else if (step[i]) cnt <= s[i] ? cnt + 16'd1 : cnt - 16'd1;
    end
    assign rc_in[i] = rc_force[i] ? 1'b0 : (s[i] ? (&cnt) : ~(|cnt));
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic run_move(input int idx, input vec_t v);
    int          cyc, nsteps, trk_err, s_err, busy_err;
    logic [15:0] cur;
    string       tag;
    tag = $sformatf("v%0d", idx);
    chk({tag, "_ready"}, 32'(ready[v.inst]), 1);
    tgt = v.tgt;
    valid[v.inst] = 1'b1;
    tick_clk();
    valid[v.inst] = 1'b0;
    cyc = 1; nsteps = 0; trk_err = 0; s_err = 0; busy_err = 0;
    cur = model_pos[v.inst];
    if (v.n != 0) chk({tag, "_setup_s"}, 32'(s[v.inst]), 32'(v.exp_s));
    while (!done[v.inst] && cyc <= v.lat + 10) begin
      if (pos[v.inst] !== cur) trk_err++;
      if (busy[v.inst] !== (v.n != 0)) busy_err++;
      if (step[v.inst]) begin
        nsteps++;
        if (s[v.inst] !== v.exp_s) s_err++;
        cur = v.exp_s ? cur + 16'd1 : cur - 16'd1;
      end
      tick_clk();
      cyc++;
    end
    if (pos[v.inst] !== cur) trk_err++;
    chk({tag, "_latency"}, 32'(cyc), 32'(v.lat));
    chk({tag, "_steps"}, 32'(nsteps), 32'(v.n));
    chk({tag, "_pos"}, 32'(pos[v.inst]), 32'(v.exp_pos));
    chk({tag, "_track_err"}, 32'(trk_err), 0);
    chk({tag, "_dir_err"}, 32'(s_err), 0);
    chk({tag, "_busy_err"}, 32'(busy_err), 0);
    chk({tag, "_fin_busy"}, 32'(busy[v.inst]), 0);
    chk({tag, "_rc_err"}, 32'(rc_err[v.inst]), 0);
    tick_clk();
    chk({tag, "_done_pulse"}, 32'(done[v.inst]), 0);
    chk({tag, "_ready_after"}, 32'(ready[v.inst]), 1);
    model_pos[v.inst] = v.exp_pos;
  endtask

  // Wait (bounded) until instance inst has emitted want step pulses; leaves us in that step cycle.
  task automatic wait_steps(input int inst, input int want, output int got);
    int cyc;
    got = 0; cyc = 0;
    while (got < want && cyc < 100) begin
      tick_clk();
      cyc++;
      if (step[inst]) got++;
    end
  endtask

  initial begin
    int n, bad;

    vecs[0] = '{0, 16'h0005, 1'b1, 5,     16'h0005, 7};
    vecs[1] = '{0, 16'h0000, 1'b0, 5,     16'h0000, 7};
    vecs[2] = '{0, 16'hFFFE, 1'b0, 2,     16'hFFFE, 4};
    vecs[3] = '{0, 16'hFFFE, 1'b0, 0,     16'hFFFE, 1};
    vecs[4] = '{0, 16'h0001, 1'b1, 3,     16'h0001, 5};
    vecs[5] = '{0, 16'h1234, 1'b1, 4659,  16'h1234, 4661};
    vecs[6] = '{0, 16'h1234, 1'b1, 0,     16'h1234, 1};
    vecs[7] = '{1, 16'h0003, 1'b1, 3,     16'h0003, 11};
    vecs[8] = '{1, 16'h0000, 1'b0, 3,     16'h0000, 11};
    vecs[9] = '{2, 16'hFFFF, 1'b1, 65535, 16'hFFFF, 65537};

    for (int i = 0; i < NI; i++) model_pos[i] = '0;
    valid = '0; abort = 1'b0; tgt = '0; rc_force = '0;
    rst = 1'b1;
    #1;
    chk("reset_ready", 32'(ready), 0);
    chk("reset_s", 32'(s), 0);
    chk("reset_step", 32'(step), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_rc_err", 32'(rc_err), 0);
    for (int i = 0; i < NI; i++) chk($sformatf("reset_pos%0d", i), 32'(pos[i]), 0);
    tick_clk();
    tick_clk();
    rst = 1'b0;
    tick_clk();
    chk("post_reset_ready", 32'(ready), 32'h7);

    for (int i = 0; i < 10; i++) run_move(i, vecs[i]);

    // Tie (diff == 0x8000) goes up; abort in a step cycle keeps that step.
    tgt = 16'h9234;
    valid[0] = 1'b1;
    tick_clk();
    valid[0] = 1'b0;
    chk("tie_s", 32'(s[0]), 1);
    chk("tie_busy", 32'(busy[0]), 1);
    wait_steps(0, 5, n);
    chk("tie_nsteps", 32'(n), 5);
    abort = 1'b1;
    tick_clk();
    abort = 1'b0;
    chk("tie_abort_pos", 32'(pos[0]), 32'h1239);
    chk("tie_abort_busy", 32'(busy[0]), 0);
    chk("tie_abort_done", 32'(done[0]), 0);
    chk("tie_abort_ready", 32'(ready[0]), 1);
    model_pos[0] = 16'h1239;

    // STEP_DIV=4: abort in the gap after the 3rd step; a target offered mid-move is dropped.
    tgt = 16'h0010;
    valid[1] = 1'b1;
    tick_clk();
    valid[1] = 1'b0;
    wait_steps(1, 3, n);
    chk("abort_nsteps", 32'(n), 3);
    tick_clk();
    chk("abort_gap_pos", 32'(pos[1]), 32'h0003);
    chk("busy_ready_low", 32'(ready[1]), 0);
    tgt = 16'h0100;
    valid[1] = 1'b1;
    abort = 1'b1;
    tick_clk();
    valid[1] = 1'b0;
    abort = 1'b0;
    chk("abort_pos", 32'(pos[1]), 32'h0003);
    chk("abort_busy", 32'(busy[1]), 0);
    chk("abort_done", 32'(done[1]), 0);
    chk("abort_ready", 32'(ready[1]), 1);
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      tick_clk();
      if (step[1] || done[1] || busy[1]) bad++;
    end
    chk("abort_idle_activity", 32'(bad), 0);
    chk("abort_pos_hold", 32'(pos[1]), 32'h0003);
    model_pos[1] = 16'h0003;

    // Rc forced low at pos=0xFFFF counting up: sticky error; move still wraps to 0.
    rc_force[2] = 1'b1;
    tgt = 16'h0000;
    valid[2] = 1'b1;
    tick_clk();
    valid[2] = 1'b0;
    chk("rc_err_before", 32'(rc_err[2]), 0);
    tick_clk();
    chk("rc_err_set", 32'(rc_err[2]), 1);
    n = 0;
    while (!done[2] && n < 10) begin
      tick_clk();
      n++;
    end
    chk("rc_move_done", 32'(done[2]), 1);
    chk("rc_move_wrap_pos", 32'(pos[2]), 0);
    rc_force[2] = 1'b0;
    for (int c = 0; c < 4; c++) tick_clk();
    chk("rc_err_sticky", 32'(rc_err[2]), 1);
    chk("rc_err_others", 32'(rc_err[1:0]), 0);

    // Asynchronous reset in the middle of a move.
    tgt = 16'h0010;
    valid[1] = 1'b1;
    tick_clk();
    valid[1] = 1'b0;
    wait_steps(1, 2, n);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_s", 32'(s), 0);
    chk("midrst_step", 32'(step), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_rc_err", 32'(rc_err), 0);
    chk("midrst_ready", 32'(ready), 0);
    for (int i = 0; i < NI; i++) chk($sformatf("midrst_pos%0d", i), 32'(pos[i]), 0);
    tick_clk();
    rst = 1'b0;
    tick_clk();
    chk("midrst_ready_after", 32'(ready), 32'h7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rev_step_driver.md
Name: rev_step_driver

Overview:
Initiator for the reversible up/down counter interface. It accepts a 16-bit target position over a valid/ready handshake and drives the counter's direction (s) and a one-cycle step enable until the counter reaches the target. It keeps a mirror of the counter value (pos) and checks the counter's ripple-carry (Rc) against that mirror. It sits between a control/FSM layer and one or more cascaded reversible counters.

Parameters:
WIDTH, 16, counter/target width
STEP_DIV, 4, clock cycles per step (>=1); step pulses spaced STEP_DIV cycles apart
SHORTEST, 1, 1 = pick the shorter wrap-around direction; 0 = always count up

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
tgt_valid  in  1  target offered
tgt_ready  out  1  target accepted when valid & ready
tgt  in  WIDTH  target position
abort  in  1  cancel an in-progress move
s  out  1  direction to counter: 1 = up, 0 = down
step  out  1  one-cycle count enable to counter
pos  out  WIDTH  mirror of counter value after each step
rc_in  in  1  Rc from counter (combinational from its cnt and s)
busy  out  1  move in progress
done  out  1  one-cycle pulse when a move completes
rc_err  out  1  sticky Rc mismatch flag

Behaviour:
- Reset (asynchronous, takes effect immediately): s=0, step=0, pos=0, busy=0, done=0, rc_err=0, tgt_ready=0. FSM enters IDLE.
- States: IDLE, SETUP, STEP, GAP, FIN.
- IDLE:
  - tgt_ready=1.
  - On valid&ready: latch tgt, compute diff = (tgt - pos) mod 2^WIDTH.
  - diff==0 -> FIN. Otherwise -> SETUP with busy=1.
- Direction/count, computed in SETUP:
  - If SHORTEST=1 and diff > 2^(WIDTH-1): s=0, remaining = 2^WIDTH - diff.
  - Otherwise: s=1, remaining = diff.
  - Tie at exactly 2^(WIDTH-1) goes up.
  - s is registered here, so it is stable at least one cycle before the first step and does not change during the move.
- STEP:
  - step=1 for one cycle.
  - On the same edge: pos <= pos ± 1 (modulo wrap: 0xFFFF+1 -> 0x0000, 0x0000-1 -> 0xFFFF), remaining decrements.
  - remaining reaches 0 -> FIN. Otherwise -> GAP if STEP_DIV>1, else STEP again.
- GAP: holds for STEP_DIV-1 cycles with step=0, then -> STEP.
- FIN: done=1 for one cycle, busy=0, -> IDLE. tgt_ready returns high in the next cycle.
- Latency:
  - Target of N steps: done asserts 2 + (N-1)*STEP_DIV + 1 cycles after acceptance.
  - diff==0: done asserts 1 cycle after acceptance.
- tgt_ready=0 in every state except IDLE. tgt_valid while busy is ignored, not queued.
- abort (sampled while busy, outside FIN):
  - The next edge goes to IDLE with no further step and no done pulse.
  - pos holds its last value. A step already asserted in the same cycle still counts.
- Rc check: rc_exp = s ? (&pos) : ~|pos.
  - Whenever busy=1 and rc_in != rc_exp, rc_err is set on the next edge.
  - rc_err clears only on rst.
  - Not checked in IDLE (s may be stale in the external counter).
- pos must track the external counter. Both must be reset together; the driver has no way to read cnt.

Decomposition:
- Shared package: FSM state enum, direction constants DIR_UP=1 / DIR_DOWN=0, WIDTH default.
- One natural sub-module: rev_step_pacer. It is the STEP_DIV cycle divider, producing a step strobe while enabled and restarting on enable rise.

Test Plan:
1. Reset -> tgt=0x0005, STEP_DIV=1 -> s=1, exactly 5 step pulses on consecutive cycles, pos=0x0005, done one cycle later.
2. pos=0x0000, tgt=0xFFFE, SHORTEST=1 -> s=0, 2 steps, pos passes 0xFFFF then 0xFFFE. With rc_in from a model counter, the Rc check runs and rc_err stays 0.
3. pos=0x0000, tgt=0x8000, SHORTEST=1 -> tie goes up, s=1, 32768 steps; repeat with SHORTEST=0 and tgt=0xFFFF -> 65535 up steps, pos=0xFFFF.
4. tgt==pos (0x1234) -> no step, done 1 cycle after acceptance, busy never asserts beyond FIN.
5. tgt=0x0010, STEP_DIV=4, abort after the 3rd step -> pos=0x0003, no done, tgt_ready=1 next cycle. Also: tgt_valid during the move is ignored.
6. Force rc_in=0 while pos=0xFFFF, s=1 -> rc_err=1 and stays set. Assert rst mid-move -> all outputs at reset values immediately, rc_err=0.
